// File: rtl/pipelined_control_unit.sv
// MIPS control unit: D-stage decode, E/M/W control pipeline and a MULT result scoreboard.
// Define CU_ILLEGAL_OP_EN to add the sticky Illegal_Op flag for undefined encodings.
module pipelined_control_unit #(
    parameter int ALU_OP_W    = 4,
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          Op_Code,
    input  logic [5:0]          Funct,
    input  logic                Flush_E,
    output logic                Jump_D,
    output logic                Jump_Reg_D,
    output logic                Mul_Stall_D,
    output logic                Mul_Busy,
    output logic                Reg_Dst_E,
    output logic                ALU_Src_E,
    output logic                Branch_E,
    output logic                Branch_Ne_E,
    output logic                Link_E,
    output logic [ALU_OP_W-1:0] ALU_Ctrl_E,
    output logic                Mem_Read_M,
    output logic                Mem_Write_M,
    output logic                Reg_Write_W,
    output logic                Mem_To_Reg_W
`ifdef CU_ILLEGAL_OP_EN
    ,
    output logic                Illegal_Op
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_LUI  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_MFLO = 4'd10;
    localparam logic [3:0] ALU_MFHI = 4'd11;
    localparam logic [3:0] ALU_MULT = 4'd12;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       link;
        logic [3:0] alu;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    ctrl_t            dec_s;
    ctrl_t            e_d;
    ctrl_t            e_q;
    logic             jump_s;
    logic             jump_reg_s;
    logic             is_mult_s;
    logic             is_mfx_s;
    logic             r_known_s;
    logic             capture_s;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_read_m_q;
    logic             mem_write_m_q;
    logic             reg_write_m_q;
    logic             mem_to_reg_m_q;
    logic             reg_write_w_q;
    logic             mem_to_reg_w_q;

    // D-stage decode of Op_Code/Funct into the control bundle.
    always_comb begin
        dec_s      = '0;
        jump_s     = 1'b0;
        jump_reg_s = 1'b0;
        is_mult_s  = 1'b0;
        is_mfx_s   = 1'b0;
        r_known_s  = 1'b0;
        case (Op_Code)
            OP_RTYPE: begin
                r_known_s = 1'b1;
                case (Funct)
                    FN_ADD:  dec_s.alu = ALU_ADD;
                    FN_SUB:  dec_s.alu = ALU_SUB;
                    FN_AND:  dec_s.alu = ALU_AND;
                    FN_OR:   dec_s.alu = ALU_OR;
                    FN_SLT:  dec_s.alu = ALU_SLT;
                    FN_XOR:  dec_s.alu = ALU_XOR;
                    FN_NOR:  dec_s.alu = ALU_NOR;
                    FN_SLL:  dec_s.alu = ALU_SLL;
                    FN_SRL:  dec_s.alu = ALU_SRL;
                    FN_MULT: begin
                        dec_s.alu = ALU_MULT;
                        is_mult_s = 1'b1;
                    end
                    FN_MFLO: begin
                        dec_s.alu = ALU_MFLO;
                        is_mfx_s  = 1'b1;
                    end
                    FN_MFHI: begin
                        dec_s.alu = ALU_MFHI;
                        is_mfx_s  = 1'b1;
                    end
                    FN_JR:   jump_reg_s = 1'b1;
                    default: r_known_s  = 1'b0;
                endcase
                // MULT writes HI/LO and JR writes nothing, so neither touches the register file.
                dec_s.reg_dst   = r_known_s;
                dec_s.reg_write = r_known_s & ~is_mult_s & ~jump_reg_s;
            end
            OP_LW: begin
                dec_s.alu_src    = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.alu        = ALU_ADD;
            end
            OP_SW: begin
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.alu       = ALU_ADD;
            end
            OP_BEQ: begin
                dec_s.branch = 1'b1;
                dec_s.alu    = ALU_SUB;
            end
            OP_BNE: begin
                dec_s.branch    = 1'b1;
                dec_s.branch_ne = 1'b1;
                dec_s.alu       = ALU_SUB;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_XORI: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                case (Op_Code)
                    OP_ANDI: dec_s.alu = ALU_AND;
                    OP_ORI:  dec_s.alu = ALU_OR;
                    OP_SLTI: dec_s.alu = ALU_SLT;
                    OP_LUI:  dec_s.alu = ALU_LUI;
                    OP_XORI: dec_s.alu = ALU_XOR;
                    default: dec_s.alu = ALU_ADD;
                endcase
            end
            OP_J: jump_s = 1'b1;
            OP_JAL: begin
                jump_s          = 1'b1;
                dec_s.link      = 1'b1;
                dec_s.reg_write = 1'b1;
            end
            default: dec_s = '0;
        endcase
    end

    assign Jump_D      = jump_s;
    assign Jump_Reg_D  = jump_reg_s;
    assign Mul_Busy    = (cnt_q != '0);
    assign Mul_Stall_D = Mul_Busy & (is_mult_s | is_mfx_s);
    assign capture_s   = ~Flush_E & ~Mul_Stall_D;

    // E-stage next state: the decode, or a bubble on flush/stall.
    always_comb begin
        if (capture_s) begin
            e_d = dec_s;
        end else begin
            e_d = '0;
        end
    end

    // Multiplier countdown: reload on a captured MULT, otherwise count down to zero.
    always_comb begin
        if (is_mult_s && capture_s) begin
            cnt_d = CNT_W'(MUL_LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // E/M/W pipeline registers and scoreboard counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q            <= '0;
            cnt_q          <= '0;
            mem_read_m_q   <= 1'b0;
            mem_write_m_q  <= 1'b0;
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
        end else begin
            e_q            <= e_d;
            cnt_q          <= cnt_d;
            mem_read_m_q   <= e_q.mem_read;
            mem_write_m_q  <= e_q.mem_write;
            reg_write_m_q  <= e_q.reg_write;
            mem_to_reg_m_q <= e_q.mem_to_reg;
            reg_write_w_q  <= reg_write_m_q;
            mem_to_reg_w_q <= mem_to_reg_m_q;
        end
    end

    assign Reg_Dst_E    = e_q.reg_dst;
    assign ALU_Src_E    = e_q.alu_src;
    assign Branch_E     = e_q.branch;
    assign Branch_Ne_E  = e_q.branch_ne;
    assign Link_E       = e_q.link;
    assign ALU_Ctrl_E   = ALU_OP_W'(e_q.alu);
    assign Mem_Read_M   = mem_read_m_q;
    assign Mem_Write_M  = mem_write_m_q;
    assign Reg_Write_W  = reg_write_w_q;
    assign Mem_To_Reg_W = mem_to_reg_w_q;

`ifdef CU_ILLEGAL_OP_EN
    logic illegal_d;
    logic illegal_q;

    function automatic logic is_undefined(input logic [5:0] op, input logic [5:0] fn);
        logic undef;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_XOR, FN_NOR,
                    FN_SLL, FN_SRL, FN_MULT, FN_MFLO, FN_MFHI, FN_JR: undef = 1'b0;
                    default: undef = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI,
            OP_SLTI, OP_LUI, OP_XORI, OP_J, OP_JAL: undef = 1'b0;
            default: undef = 1'b1;
        endcase
        return undef;
    endfunction

    // Sticky flag: only encodings that actually enter E count.
    always_comb begin
        if (capture_s && is_undefined(Op_Code, Funct)) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Illegal_Op holds until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign Illegal_Op = illegal_q;
`endif

endmodule
